game_tick_sched: RTL and testbench
==================================

// Module: game_tick_sched
// PURPOSE
//  Schedules game-state updates for the pingpong VGA path. Replaces the free-running
//  derived clock with single-cycle enables in the clk domain: programmable-rate
//  update requests to the game logic, serve countdown, pause, and overrun accounting.
//  Sits between the top-level controls and the ball/paddle update logic.
// PARAMETERS
//  BASE_DELAY  2500000  clk cycles per tick at speed 0 (min 8)
//  CNT_W       32       tick counter width; must hold BASE_DELAY-1
//  COUNTDOWN   3        serve countdown length in ticks (1..15)
//  RAMP_TICKS  64       RUN ticks per auto speed step (AUTO_SPEEDUP_EN only)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  start      in   1  1-cycle pulse: IDLE->SERVE
//  stop       in   1  1-cycle pulse: point scored / abort -> SERVE (from RUN/PAUSE)
//  pause_tgl  in   1  1-cycle pulse: RUN<->PAUSE
//  speed      in   2  requested speed level 0..3
//  upd_ack    in   1  game logic finished current update
//  tick       out  1  1-cycle pulse each period while in SERVE or RUN
//  upd_req    out  1  update request, held until acked
//  state      out  2  00 IDLE, 01 SERVE, 10 RUN, 11 PAUSE
//  cd_val     out  4  remaining serve countdown
//  missed     out  8  saturating count of ticks lost to pending upd_req
//  speed_eff  out  2  speed level in use
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, tick=0, upd_req=0, cd_val=0, missed=0, speed_eff=0.
//  - period = BASE_DELAY >> (2*speed_eff) (speeds 0..3 give /1,/4,/16,/64).
//  - Counter runs only in SERVE/RUN; when counter >= period-1: tick=1 next cycle, counter=0.
//    Counter held in IDLE/PAUSE; cleared on any entry to SERVE.
//  - Speed change mid-period: applies at once via >= compare (never a missed wrap).
//  - IDLE: no ticks. start -> SERVE, cd_val=COUNTDOWN.
//  - SERVE: each tick decrements cd_val; on tick with cd_val==1 -> RUN, cd_val=0.
//    No upd_req in SERVE. pause_tgl ignored.
//  - RUN: each tick sets upd_req=1 same cycle as tick. upd_ack clears upd_req next cycle.
//    Tick while upd_req=1 and no upd_ack that cycle: upd_req stays 1, missed += 1 (sat 255).
//    Tick and upd_ack same cycle: new request wins, upd_req stays 1, no miss.
//  - PAUSE: counter frozen, upd_req held; upd_ack still clears it. pause_tgl -> RUN, resumes count.
//  - stop in RUN/PAUSE -> SERVE: upd_req=0, counter=0, cd_val=COUNTDOWN. missed kept.
//  - Priority same cycle: stop > start > pause_tgl. upd_ack with upd_req=0 ignored.
//  - upd_req forced 0 in IDLE/SERVE; missed clears only on reset.
//  - Async reset mid-operation: immediate return to reset values, no tick emitted.
// CONFIGURATION
//  AUTO_SPEEDUP_EN defined: internal ramp level increments every RAMP_TICKS RUN ticks,
//    saturates at 3, cleared on entry to SERVE; speed_eff = max(speed, ramp level).
//  AUTO_SPEEDUP_EN undefined: speed_eff = speed registered each cycle; no ramp logic.
// TESTING (BASE_DELAY=64, COUNTDOWN=3, RAMP_TICKS=4)
//  - Reset, idle 200 cycles -> tick=0, upd_req=0, state=00, missed=0.
//  - start, speed=0 -> ticks every 64 cycles; cd_val 3,2,1; RUN after 3rd tick; first upd_req 64 cycles later.
//  - RUN, speed=2 (period 4), upd_ack 1 cycle after each req -> no miss; never ack -> missed 1,2,.. sat 255.
//  - pause_tgl at counter=10, wait 500, pause_tgl -> next tick exactly 54 cycles after resume.
//  - stop with upd_req=1 -> state=01, upd_req=0 next cycle, cd_val=3; start+stop same cycle in IDLE -> SERVE.
//  - AUTO_SPEEDUP_EN, speed=0: speed_eff 1 after 4 RUN ticks, 3 after 12, stays 3; stop -> 0.

Source files
------------

// File: rtl/game_tick_sched.sv
// game_tick_sched: clk-domain tick/update scheduler with serve countdown, pause and overrun count; AUTO_SPEEDUP_EN adds a speed ramp
module game_tick_sched #(
   parameter int BASE_DELAY = 2500000,
   parameter int CNT_W      = 32,
   parameter int COUNTDOWN  = 3,
   parameter int RAMP_TICKS = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       pause_tgl,
   input  logic [1:0] speed,
   input  logic       upd_ack,
   output logic       tick,
   output logic       upd_req,
   output logic [1:0] state,
   output logic [3:0] cd_val,
   output logic [7:0] missed,
   output logic [1:0] speed_eff
);
   typedef enum logic [1:0] {IDLE = 2'b00, SERVE = 2'b01, RUN = 2'b10, PAUSE = 2'b11} state_t;
   localparam int CD_SAFE = (COUNTDOWN < 1 || RAMP_TICKS < 1) ? 1 : COUNTDOWN;
   localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_DELAY);
   localparam logic [3:0] CD_INIT = 4'(CD_SAFE);
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, per_raw, per_m1;
   logic tick_q, tick_d, req_q, req_d, at_end;
   logic [3:0] cd_q, cd_d;
   logic [7:0] missed_q, missed_d;
   logic [1:0] spd_q, spd_d;
   assign per_raw = BASE >> {spd_q, 1'b0};
   assign per_m1  = (per_raw == '0) ? '0 : per_raw - CNT_W'(1);
   assign at_end  = cnt_q >= per_m1;
`ifdef AUTO_SPEEDUP_EN
   localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [1:0] ramp_q, ramp_d;
   // ramp level climbs every RAMP_TICKS run ticks and restarts with each serve
   always_comb begin
      rcnt_d = rcnt_q;
      ramp_d = ramp_q;
      if (state_d == SERVE && state_q != SERVE) begin
         rcnt_d = '0;
         ramp_d = 2'd0;
      end else if (state_q == RUN && state_d == RUN && at_end) begin
         rcnt_d = (rcnt_q == RW'(RAMP_TICKS - 1)) ? '0 : rcnt_q + RW'(1);
         ramp_d = (rcnt_q == RW'(RAMP_TICKS - 1) && ramp_q != 2'd3) ? ramp_q + 2'd1 : ramp_q;
      end
   end
   assign spd_d = (ramp_d > speed) ? ramp_d : speed;
   // ramp state registers
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rcnt_q <= '0;
         ramp_q <= 2'd0;
      end else begin
         rcnt_q <= rcnt_d;
         ramp_q <= ramp_d;
      end
`else
   assign spd_d = speed;
`endif
   // next-state: control pulses first (stop > start > pause), otherwise count toward the next tick
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tick_d   = 1'b0;
      req_d    = req_q && !upd_ack;
      cd_d     = cd_q;
      missed_d = missed_q;
      if (stop && (state_q == RUN || state_q == PAUSE)) begin
         state_d = SERVE;
         cnt_d   = '0;
         req_d   = 1'b0;
         cd_d    = CD_INIT;
      end else if (start && state_q == IDLE) begin
         state_d = SERVE;
         cnt_d   = '0;
         cd_d    = CD_INIT;
      end else if (pause_tgl && state_q == RUN) begin
         state_d = PAUSE;
      end else if (pause_tgl && state_q == PAUSE) begin
         state_d = RUN;
      end else if (state_q == SERVE || state_q == RUN) begin
         cnt_d  = at_end ? '0 : cnt_q + CNT_W'(1);
         tick_d = at_end;
         if (at_end && state_q == SERVE) begin
            cd_d    = cd_q - 4'd1;
            state_d = (cd_q == 4'd1) ? RUN : SERVE;
         end
         if (at_end && state_q == RUN) begin
            req_d    = 1'b1;
            missed_d = (req_q && !upd_ack && missed_q != 8'hff) ? missed_q + 8'd1 : missed_q;
         end
      end
   end
   // state registers with asynchronous reset
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         req_q    <= 1'b0;
         cd_q     <= 4'd0;
         missed_q <= 8'd0;
         spd_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         req_q    <= req_d;
         cd_q     <= cd_d;
         missed_q <= missed_d;
         spd_q    <= spd_d;
      end
   assign tick      = tick_q;
   assign upd_req   = req_q;
   assign state     = state_q;
   assign cd_val    = cd_q;
   assign missed    = missed_q;
   assign speed_eff = spd_q;
endmodule

// File: tb/tb_game_tick_sched.sv
// tb_game_tick_sched: directed and randomized checks of game_tick_sched against a behavioural model
module tb_game_tick_sched;
   localparam int BASE = 64;
   localparam int CD   = 3;
   localparam int RT   = 4;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, pause_tgl = 1'b0, upd_ack = 1'b0;
   logic [1:0] speed = 2'd0;
   logic tick, upd_req;
   logic [1:0] state, speed_eff;
   logic [3:0] cd_val;
   logic [7:0] missed;
   int checks = 0, passed = 0;
   int m_st, m_cnt, m_cd, m_missed, m_spd, m_ramp, m_rt, m_tick, m_req;
   int n, m0;
   always #5 clk = ~clk;
   game_tick_sched #(.BASE_DELAY(BASE), .CNT_W(32), .COUNTDOWN(CD), .RAMP_TICKS(RT)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pause_tgl(pause_tgl),
      .speed(speed), .upd_ack(upd_ack), .tick(tick), .upd_req(upd_req), .state(state),
      .cd_val(cd_val), .missed(missed), .speed_eff(speed_eff)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask
   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_cd = 0; m_missed = 0; m_spd = 0; m_ramp = 0; m_rt = 0; m_tick = 0; m_req = 0;
   endtask
   // one clock of the game rules: m_cnt is the number of cycles already spent in the current period
   task automatic model();
      int per, prev;
      prev = m_st;
      per = BASE >> (2 * m_spd);
      if (per < 1) per = 1;
      m_tick = 0;
      if (stop && m_st >= 2) begin
         m_st = 1; m_cnt = 0; m_req = 0; m_cd = CD;
      end else if (start && m_st == 0) begin
         m_st = 1; m_cnt = 0; m_cd = CD;
      end else if (m_st == 3 || (m_st == 2 && pause_tgl)) begin
         if (pause_tgl) m_st = (m_st == 2) ? 3 : 2;
         if (upd_ack) m_req = 0;
      end else if (m_st != 0) begin
         m_cnt++;
         if (m_cnt < per) begin
            if (upd_ack) m_req = 0;
         end else begin
            m_cnt = 0;
            m_tick = 1;
            if (m_st == 1) begin
               m_cd--;
               if (m_cd == 0) m_st = 2;
            end else begin
               if (m_req == 1 && !upd_ack && m_missed < 255) m_missed++;
               m_req = 1;
               m_rt++;
               if (m_rt == RT) begin
                  m_rt = 0;
                  if (m_ramp < 3) m_ramp++;
               end
            end
         end
      end
      if (m_st == 1 && prev != 1) begin
         m_ramp = 0; m_rt = 0;
      end
`ifdef AUTO_SPEEDUP_EN
      m_spd = (m_ramp > int'(speed)) ? m_ramp : int'(speed);
`else
      m_spd = int'(speed);
`endif
   endtask
   task automatic step();
      model();
      @(posedge clk);
      #1;
      chk("tick", 32'(tick), m_tick);
      chk("upd_req", 32'(upd_req), m_req);
      chk("state", 32'(state), m_st);
      chk("cd_val", 32'(cd_val), m_cd);
      chk("missed", 32'(missed), m_missed);
      chk("speed_eff", 32'(speed_eff), m_spd);
      start = 1'b0; stop = 1'b0; pause_tgl = 1'b0; upd_ack = 1'b0;
   endtask
   task automatic wait_tick(output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!tick && cyc < 400);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_tick"}, 32'(tick), 0);
      chk({tag, "_req"}, 32'(upd_req), 0);
      chk({tag, "_state"}, 32'(state), 0);
      chk({tag, "_cd"}, 32'(cd_val), 0);
      chk({tag, "_missed"}, 32'(missed), 0);
      chk({tag, "_speed"}, 32'(speed_eff), 0);
   endtask
   initial begin
      model_reset();
      #12;
      chk_zero("reset");
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (200) step();
      chk("idle_state", 32'(state), 0);
`ifdef AUTO_SPEEDUP_EN
      start = 1'b1;
      step();
      repeat (3) wait_tick(n);
      chk("run_entered", 32'(state), 2);
      repeat (4) wait_tick(n);
      chk("ramp1_tick", 32'(tick), 1);
      chk("ramp1", 32'(speed_eff), 1);
      repeat (8) wait_tick(n);
      chk("ramp3", 32'(speed_eff), 3);
      repeat (4) wait_tick(n);
      chk("ramp3_hold", 32'(speed_eff), 3);
      stop = 1'b1;
      step();
      chk("ramp_clear", 32'(speed_eff), 0);
`else
      start = 1'b1;
      step();
      chk("serve_state", 32'(state), 1);
      chk("serve_cd", 32'(cd_val), 3);
      wait_tick(n);
      chk("serve_gap1", n, 64);
      chk("cd_after1", 32'(cd_val), 2);
      wait_tick(n);
      chk("serve_gap2", n, 64);
      chk("cd_after2", 32'(cd_val), 1);
      wait_tick(n);
      chk("serve_gap3", n, 64);
      chk("run_state", 32'(state), 2);
      chk("run_cd", 32'(cd_val), 0);
      chk("no_req_serve", 32'(upd_req), 0);
      wait_tick(n);
      chk("first_req_gap", n, 64);
      chk("first_req", 32'(upd_req), 1);
      upd_ack = 1'b1;
      step();
      speed = 2'd2;
      repeat (40) begin
         upd_ack = tick;
         step();
      end
      chk("acked_no_miss", 32'(missed), 0);
      wait_tick(n);
      m0 = m_missed;
      wait_tick(n);
      chk("period4_gap", n, 4);
      chk("miss_inc", 32'(missed), 32'(m0 + 1));
      speed = 2'd3;
      repeat (300) step();
      chk("miss_sat", 32'(missed), 255);
      speed = 2'd0;
      wait_tick(n);
      repeat (10) step();
      pause_tgl = 1'b1;
      step();
      chk("pause_state", 32'(state), 3);
      repeat (250) step();
      chk("pause_req_held", 32'(upd_req), 1);
      upd_ack = 1'b1;
      step();
      chk("pause_ack_clr", 32'(upd_req), 0);
      repeat (249) step();
      pause_tgl = 1'b1;
      step();
      chk("resume_state", 32'(state), 2);
      wait_tick(n);
      chk("resume_gap", n, 54);
      chk("resume_req", 32'(upd_req), 1);
      stop = 1'b1;
      step();
      chk("stop_state", 32'(state), 1);
      chk("stop_req", 32'(upd_req), 0);
      chk("stop_cd", 32'(cd_val), 3);
      chk("stop_keeps_missed", 32'(missed), 255);
`endif
      repeat (5) step();
      #3 reset = 1'b1;
      #1;
      chk_zero("async_reset");
      model_reset();
      speed = 2'd0;
      @(posedge clk);
      #1 reset = 1'b0;
      start = 1'b1;
      stop = 1'b1;
      step();
      chk("start_stop_idle", 32'(state), 1);
      for (int i = 0; i < 2500; i++) begin
         if (i % 64 == 0) speed = 2'($urandom_range(1, 3));
         start = ($urandom_range(0, 19) == 0);
         stop = ($urandom_range(0, 99) == 0);
         pause_tgl = ($urandom_range(0, 49) == 0);
         upd_ack = 1'($urandom_range(0, 1));
         step();
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
